// File: rtl/text_pixel_gen.sv
// VT52 text-mode pixel generator: 80x24 cell decode, font lookup,
// glyph serialiser and blinking block cursor, fixed 4-clock latency.
module text_pixel_gen #(
  parameter int COLS         = 80,
  parameter int ROWS         = 24,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        cursor_en,
  output logic        pixel,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);
  localparam logic [11:0] COLS_W = 12'(COLS);

  typedef struct packed {
    logic [3:0] grow;
    logic [2:0] xbit;
    logic       inr;
    logic       hit;
    logic       de;
    logic       hs;
    logic       vs;
  } side_t;

  logic [6:0]    col;
  logic [5:0]    row;
  logic          in_range;
  logic          cursor_hit;
  logic [11:0]   addr_d;
  side_t         s0_d;
  side_t         s0;
  side_t         s1;
  side_t         s2;
  logic          blink_on;
  logic          vs_prev;
  logic          vs_rise;
  logic [FW-1:0] frame_cnt;

  always_comb begin
    col        = x_in[9:3];
    row        = y_in[9:4];
    in_range   = de_in
               & (32'(col) < COLS)
               & (32'(row) < ROWS);
    cursor_hit = cursor_en & blink_on
               & (col == cursor_x)
               & (row == {1'b0, cursor_y});
    addr_d     = '0;
    if (in_range)
      addr_d = 12'(row) * COLS_W + 12'(col);
    s0_d.grow  = y_in[3:0];
    s0_d.xbit  = x_in[2:0];
    s0_d.inr   = in_range;
    s0_d.hit   = cursor_hit;
    s0_d.de    = de_in;
    s0_d.hs    = hs_in;
    s0_d.vs    = vs_in;
  end

  assign vs_rise = vs_in & ~vs_prev;

  // One blink half-period every BLINK_FRAMES vsync rising edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev   <= 1'b0;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      vs_prev <= vs_in;
      if (vs_rise) begin
        if (frame_cnt == FLAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      text_addr <= '0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      pixel     <= 1'b0;
      de_out    <= 1'b0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
    end else begin
      text_addr <= addr_d;
      s0        <= s0_d;
      s1        <= s0;
      s2        <= s1;
      pixel     <= s2.inr
                 & (font_data[3'd7 - s2.xbit] ^ s2.hit);
      de_out    <= s2.de;
      hs_out    <= s2.hs;
      vs_out    <= s2.vs;
    end
  end

  // text_data lines up with stage 1, so the ROM address is formed there
  assign font_addr = {text_data, s1.grow};

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: cell-level reference model with a
// 4-deep expectation queue, directed scenarios plus random video.
module tb_text_pixel_gen;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_in;
  logic [9:0]  y_in;
  logic        de_in;
  logic        hs_in;
  logic        vs_in;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        cursor_en;
  logic        pixel;
  logic        de_out;
  logic        hs_out;
  logic        vs_out;

  text_pixel_gen #(
    .COLS(80),
    .ROWS(24),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .x_in(x_in),
    .y_in(y_in),
    .de_in(de_in),
    .hs_in(hs_in),
    .vs_in(vs_in),
    .text_addr(text_addr),
    .text_data(text_data),
    .font_addr(font_addr),
    .font_data(font_data),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .cursor_en(cursor_en),
    .pixel(pixel),
    .de_out(de_out),
    .hs_out(hs_out),
    .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  logic [7:0] tram [4096];
  logic [7:0] rom  [4096];

  always @(posedge clk) begin
    text_data <= tram[text_addr];
    font_data <= rom[font_addr];
  end

  int checks = 0;
  int errors = 0;
  int edges;
  logic vprev;
  logic [3:0] q[$];

  task automatic fill_rom(input bit zero);
    for (int i = 0; i < 4096; i++)
      rom[i] = zero ? 8'h00 : 8'($urandom);
  endtask

  task automatic model_reset();
    q.delete();
    repeat (3) q.push_back(4'b0000);
    edges = 0;
    vprev = 1'b0;
  endtask

  function automatic void model(
    input logic [9:0] x, input logic [9:0] y,
    input logic d, input logic h, input logic v,
    output logic [3:0] r, output logic [11:0] a);
    int col, row, xb;
    bit inr, blink, hit;
    logic [7:0] ch, g;
    col   = int'(x) / 8;
    row   = int'(y) / 16;
    xb    = int'(x) % 8;
    inr   = d && col < 80 && row < 24;
    a     = inr ? 12'(row * 80 + col) : 12'd0;
    ch    = tram[a];
    g     = rom[{ch, y[3:0]}];
    blink = ((edges / BF) % 2) == 0;
    hit   = cursor_en && blink
         && col == int'(cursor_x) && row == int'(cursor_y);
    r = {inr && (g[7 - xb] ^ hit), d, h, v};
  endfunction

  task automatic step(
    input logic [9:0] x, input logic [9:0] y,
    input logic d, input logic h, input logic v,
    output logic [3:0] e, output logic [11:0] a);
    logic [3:0] r;
    x_in  = x;
    y_in  = y;
    de_in = d;
    hs_in = h;
    vs_in = v;
    model(x, y, d, h, v, r, a);
    q.push_back(r);
    if (v && !vprev) edges++;
    vprev = v;
    @(posedge clk);
    #1;
    e = q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x_in = '0; y_in = '0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    cursor_x = '0; cursor_y = '0; cursor_en = 1'b0;
    #2;
    checks++;
    if ({text_addr, pixel, de_out, hs_out, vs_out} !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0",
        {text_addr, pixel, de_out, hs_out, vs_out});
    end
    de_in = 1'b1; hs_in = 1'b1; x_in = 10'd9; y_in = 10'd40;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({text_addr, pixel, de_out, hs_out, vs_out} !== 16'h0) begin
      errors++;
      $display("FAIL reset_held: got %h want 0",
        {text_addr, pixel, de_out, hs_out, vs_out});
    end
    checks++;
    if (font_addr !== {text_data, 4'h0}) begin
      errors++;
      $display("FAIL reset_font_addr: got %h want %h",
        font_addr, {text_data, 4'h0});
    end
    de_in = 1'b0; hs_in = 1'b0; x_in = '0; y_in = '0;
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [3:0] e;
    logic [11:0] a;
    logic [7:0] seen;
    seen = '0;
    cursor_en = 1'b0;
    tram[0] = 8'h41;
    rom[12'h415] = 8'h18;
    for (int k = 0; k < 11; k++) begin
      step(10'(k), 10'd5, k < 8, 1'b0, 1'b0, e, a);
      checks++;
      if ({pixel, de_out, hs_out, vs_out} !== e) begin
        errors++;
        $display("FAIL basic_pipe: got %b want %b",
          {pixel, de_out, hs_out, vs_out}, e);
      end
      if (k == 0) begin
        checks++;
        if (text_addr !== 12'd0) begin
          errors++;
          $display("FAIL basic_text_addr: got %h want 000", text_addr);
        end
      end
      if (k == 1) begin
        checks++;
        if (font_addr !== 12'h415) begin
          errors++;
          $display("FAIL basic_font_addr: got %h want 415", font_addr);
        end
      end
      if (k >= 3) seen[7 - (k - 3)] = pixel;
    end
    checks++;
    if (seen !== 8'b0001_1000) begin
      errors++;
      $display("FAIL basic_pixels: got %b want 00011000", seen);
    end
  endtask

  task automatic test_addr_map();
    logic [3:0] e;
    logic [11:0] a;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: step(10'd639, 10'd383, 1'b1, 1'b0, 1'b0, e, a);
        1: step(10'd640, 10'd383, 1'b1, 1'b0, 1'b0, e, a);
        default: step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, e, a);
      endcase
      checks++;
      if ({pixel, de_out, hs_out, vs_out} !== e || text_addr !== a) begin
        errors++;
        $display("FAIL addr_pipe: got %b/%h want %b/%h",
          {pixel, de_out, hs_out, vs_out}, text_addr, e, a);
      end
      if (k == 0) begin
        checks++;
        if (text_addr !== 12'd1919) begin
          errors++;
          $display("FAIL addr_max: got %0d want 1919", text_addr);
        end
      end
      if (k == 1) begin
        checks++;
        if (text_addr !== 12'd0) begin
          errors++;
          $display("FAIL addr_col80: got %0d want 0", text_addr);
        end
      end
      if (k == 4) begin
        checks++;
        if (pixel !== 1'b0 || de_out !== 1'b1) begin
          errors++;
          $display("FAIL addr_col80_pixel: got %b%b want 01",
            pixel, de_out);
        end
      end
    end
  endtask

  task automatic flush(input string tag);
    logic [3:0] e;
    logic [11:0] a;
    repeat (5) begin
      step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, e, a);
      checks++;
      if ({pixel, de_out, hs_out, vs_out} !== e) begin
        errors++;
        $display("FAIL %s_flush: got %b want %b", tag,
          {pixel, de_out, hs_out, vs_out}, e);
      end
    end
  endtask

  task automatic cursor_scan(input int x0, input int x1,
                             input int y0, input int y1);
    logic [3:0] e;
    logic [11:0] a;
    int hx[$];
    int hy[$];
    bit want;
    repeat (3) begin hx.push_back(-1); hy.push_back(-1); end
    for (int y = y0; y <= y1 + 1; y++)
      for (int x = x0; x <= x1; x++) begin
        step(10'(x), 10'(y), y <= y1, 1'b0, 1'b0, e, a);
        hx.push_back(y <= y1 ? x : -1);
        hy.push_back(y);
        checks++;
        if ({pixel, de_out, hs_out, vs_out} !== e) begin
          errors++;
          $display("FAIL cursor_pipe x=%0d y=%0d: got %b want %b",
            x, y, {pixel, de_out, hs_out, vs_out}, e);
        end
        if (hx[0] >= 0) begin
          want = cursor_en && hx[0] >= 16 && hx[0] <= 23
              && hy[0] >= 16 && hy[0] <= 31;
          checks++;
          if (pixel !== want) begin
            errors++;
            $display("FAIL cursor_cell x=%0d y=%0d: got %b want %b",
              hx[0], hy[0], pixel, want);
          end
        end
        void'(hx.pop_front());
        void'(hy.pop_front());
      end
  endtask

  task automatic test_cursor();
    flush("cursor");
    fill_rom(1'b1);
    cursor_x = 7'd2;
    cursor_y = 5'd1;
    cursor_en = 1'b1;
    cursor_scan(0, 31, 0, 39);
    cursor_en = 1'b0;
    cursor_scan(8, 31, 12, 35);
    flush("cursor_off");
  endtask

  task automatic test_blink();
    logic [3:0] e;
    logic [11:0] a;
    logic [5:0] pat;
    pat = 6'b100110;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    cursor_x = '0;
    cursor_y = '0;
    cursor_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (i == 4 ? 5 : 1) begin
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, e, a);
        checks++;
        if ({pixel, de_out, hs_out, vs_out} !== e) begin
          errors++;
          $display("FAIL blink_pipe: got %b want %b",
            {pixel, de_out, hs_out, vs_out}, e);
        end
      end
      for (int k = 0; k < 4; k++) begin
        step(10'd0, 10'd0, k == 0, 1'b0, 1'b0, e, a);
        checks++;
        if ({pixel, de_out, hs_out, vs_out} !== e) begin
          errors++;
          $display("FAIL blink_pipe: got %b want %b",
            {pixel, de_out, hs_out, vs_out}, e);
        end
      end
      checks++;
      if (pixel !== pat[5 - i]) begin
        errors++;
        $display("FAIL blink_edge%0d: got %b want %b",
          i + 1, pixel, pat[5 - i]);
      end
    end
    flush("blink");
    fill_rom(1'b0);
  endtask

  task automatic test_sync();
    logic [3:0] e;
    logic [11:0] a;
    logic [2:0] in_h[20];
    logic [2:0] out_h[20];
    logic d, h, v;
    cursor_en = 1'b0;
    for (int s = 0; s < 20; s++) begin
      h = (s == 2);
      v = (s == 5);
      d = (s == 8);
      in_h[s] = {d, h, v};
      step(10'd700, 10'd0, d, h, v, e, a);
      out_h[s] = {de_out, hs_out, vs_out};
      checks++;
      if ({pixel, de_out, hs_out, vs_out} !== e) begin
        errors++;
        $display("FAIL sync_pipe: got %b want %b",
          {pixel, de_out, hs_out, vs_out}, e);
      end
    end
    for (int s = 3; s < 20; s++) begin
      checks++;
      if (out_h[s] !== in_h[s - 3]) begin
        errors++;
        $display("FAIL sync_align s=%0d: got %b want %b",
          s, out_h[s], in_h[s - 3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    logic [11:0] a;
    cursor_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(10'(k * 3), 10'd50, 1'b1, 1'b1, 1'b0, e, a);
      checks++;
      if ({pixel, de_out, hs_out, vs_out} !== e) begin
        errors++;
        $display("FAIL rmid_pre: got %b want %b",
          {pixel, de_out, hs_out, vs_out}, e);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({text_addr, pixel, de_out, hs_out, vs_out} !== 16'h0) begin
      errors++;
      $display("FAIL rmid_async: got %h want 0",
        {text_addr, pixel, de_out, hs_out, vs_out});
    end
    #2 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      step(10'(40 + k), 10'd50, 1'b1, k < 2, 1'b0, e, a);
      checks++;
      if ({pixel, de_out, hs_out, vs_out} !== e) begin
        errors++;
        $display("FAIL rmid_post k=%0d: got %b want %b", k,
          {pixel, de_out, hs_out, vs_out}, e);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    logic [11:0] a;
    logic [9:0] x, y;
    logic d, h, v;
    flush("random");
    for (int i = 0; i < 4096; i++) tram[i] = 8'($urandom);
    for (int k = 0; k < 600; k++) begin
      x = 10'($urandom_range(0, 799));
      y = 10'($urandom_range(0, 524));
      d = ($urandom % 8) != 0;
      h = ($urandom % 10) == 0;
      v = ($urandom % 20) == 0;
      if ($urandom % 2) begin
        cursor_x = x[9:3];
        cursor_y = y[8:4];
      end
      cursor_en = ($urandom % 4) != 0;
      step(x, y, d, h, v, e, a);
      checks++;
      if ({pixel, de_out, hs_out, vs_out} !== e || text_addr !== a) begin
        errors++;
        $display("FAIL random k=%0d: got %b/%h want %b/%h", k,
          {pixel, de_out, hs_out, vs_out}, text_addr, e, a);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tram[i] = 8'($urandom);
    fill_rom(1'b0);
    test_reset();
    test_basic();
    test_addr_map();
    test_cursor();
    test_blink();
    test_sync();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule

// File: doc/text_pixel_gen.md
Name: text_pixel_gen

Overview:
- Text-mode pixel generator for the VT52 terminal display, driven by the video timing generator at one pixel per clock.
- Maps pixel coordinates to an 80x24 text-buffer address and reads the character code.
- Builds the 12-bit font address for the 4Kx8 character ROM and serialises the returned glyph byte into a 1-bit pixel stream.
- Also applies a blinking block cursor and delays sync/blank to match pipeline latency.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 24, text rows per screen.
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1).

Ports:
- clk  input  1  pixel clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- x_in  input  10  pixel column from timing generator.
- y_in  input  10  pixel line from timing generator.
- de_in  input  1  display-enable for this pixel.
- hs_in  input  1  hsync for this pixel.
- vs_in  input  1  vsync for this pixel.
- text_addr  output  12  text-buffer read address, registered.
- text_data  input  8  character code; text buffer has 1-clock registered read latency.
- font_addr  output  12  character ROM address {char[7:0], glyph_row[3:0]}, combinational from pipeline registers.
- font_data  input  8  glyph byte; ROM has 1-clock registered read latency; bit 7 is leftmost pixel.
- cursor_x  input  7  cursor column.
- cursor_y  input  5  cursor row.
- cursor_en  input  1  cursor visible when 1.
- pixel  output  1  foreground pixel, registered.
- de_out  output  1  de_in delayed to align with pixel.
- hs_out  output  1  hs_in delayed to align with pixel.
- vs_out  output  1  vs_in delayed to align with pixel.

Behaviour:
- Cell decode: col = x_in[9:3], glyph_row = y_in[3:0], row = y_in[9:4].
- in_range = de_in & (col < COLS) & (row < ROWS).
- Stage 0 (edge n+1): text_addr <= in_range ? row*COLS+col : 0. Registered alongside: glyph_row, x_in[2:0], in_range, cursor_hit, de, hs, vs.
  - cursor_hit = cursor_en & blink_on & (col==cursor_x) & (row==cursor_y).
- Stage 1 (edge n+2): text_data valid. Stage-1 side registers hold the stage-0 sidebands. font_addr = {text_data, glyph_row_s1}, combinational.
- Stage 2 (edge n+3): font_data valid. Sidebands delayed one more stage.
- Stage 3 (edge n+4): pixel <= in_range_s2 & (font_data[7 - xbit_s2] ^ cursor_hit_s2). de_out/hs_out/vs_out registered from stage 2.
- Total latency: exactly 4 clocks from inputs to pixel/de_out/hs_out/vs_out, every cycle, fully pipelined, no stalls.
- Outside in_range: pixel = 0 regardless of cursor. Cursor never shows outside COLS/ROWS.
- Blink:
  - frame_cnt increments on each vs_in rising edge (0->1 across consecutive clocks). A vs_in held high counts once.
  - When frame_cnt == BLINK_FRAMES-1 on a rising edge: frame_cnt <= 0 and blink_on toggles.
  - frame_cnt width is clog2(BLINK_FRAMES), minimum 1.
  - A blink_on change is seen by stage 0 on the next clock; in-flight pixels are unaffected.
- Cursor inputs may change at any time; they are sampled per pixel at stage 0 only.
- Reset asserted (async, immediate, no clock needed):
  - text_addr=0, pixel=0, de_out=0, hs_out=0, vs_out=0.
  - All pipeline registers 0, frame_cnt=0, blink_on=1.
- font_addr during reset = {text_data, 4'h0}.
- Reset release mid-frame: the first valid pixel appears 4 clocks after the first post-reset sampled input. No recovery sequence.
- text_addr maximum is (ROWS*COLS-1) = 1919 with defaults. Arithmetic is unsigned, no wrap.

Test Plan:
- Models: text RAM holds 0x41 at address 0; ROM model holds 0x18 at 0x415. Drive de_in=1, y_in=5, x_in=0..7 on consecutive clocks -> text_addr=0 at edge 1, font_addr=0x415 during cycle 2, pixel sequence 0,0,0,1,1,0,0,0 at edges 4..11.
- Address map: x_in=639, y_in=383, de_in=1 -> text_addr=1919 (0x77F) one edge later. x_in=640 -> text_addr=0, pixel=0 four edges later.
- Cursor: cursor_x=2, cursor_y=1, cursor_en=1, all-zero glyphs -> pixel=1 exactly for x=16..23, y=16..31. Same with cursor_en=0 -> pixel all 0.
- Blink with BLINK_FRAMES=2: vs_in rising edges 1,2,3,4 -> blink_on 1,0,0,1 after edges 1..4. vs_in held high 5 clocks counts as one edge. Cursor cells show pixel=1 only while blink_on=1.
- Sync alignment: pulse hs_in, vs_in, de_in on different single cycles -> each reappears on hs_out/vs_out/de_out exactly 4 clocks later with identical width.
- Async reset mid-line: assert reset between clock edges during active video -> pixel/de_out/hs_out/vs_out/text_addr go 0 before the next edge. Deassert -> correct pixels resume 4 clocks after the next sampled input.
